// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Request/response bundle for one requester of the unified memory arbiter.
//   One instance per requester (CPU, loader/DMA).
//
//   req   requester -> arbiter  access request, held with we/addr/wdata until ack
//   we    requester -> arbiter  1 = write, 0 = read
//   addr  requester -> arbiter  access address
//   wdata requester -> arbiter  write data
//   ack   arbiter -> requester  one-cycle completion pulse
//   rdata arbiter -> requester  read data, valid while ack is high
//   stall arbiter -> requester  req & ~ack, requester holds its state while high
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;
    logic          stall;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, stall
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Serialises accesses from two requesters onto the single unified
//   instruction/data memory of the multicycle MIPS. Port 0 is the CPU,
//   port 1 is the program loader / debug DMA. Ties are broken round-robin
//   with port 0 winning the first tie after reset.
//
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset, aborts any access in flight
//   port0      CPU requester bundle (slave side)
//   port1      loader/DMA requester bundle (slave side)
//   mem_addr   memory address (latched request address)
//   mem_wdata  memory write data (latched request data)
//   mem_we     memory write strobe, first ACCESS cycle of a write only
//   mem_re     memory read enable, every ACCESS cycle of a read
//   mem_rdata  memory read data, valid at the end of the last ACCESS cycle
//   busy       high in ACCESS or RESP
//
//   state  | meaning
//   IDLE   | evaluate requests, latch the winner
//   ACCESS | drive memory for MEM_LAT cycles
//   RESP   | one-cycle ack to the granted port
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     port0,
    mem_port_arbiter_if.slave     port1,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DW-1:0]         mem_rdata,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    logic [1:0]    state;
    logic          gnt;
    logic          last;
    logic          lat_we;
    logic [3:0]    cnt;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic          gnt_next;
    logic          any_req;

    // Single requester wins outright; on a tie the port that did not win
    // last time is chosen.
    assign any_req  = port0.req | port1.req;
    assign gnt_next = (port0.req & port1.req) ? ~last : port1.req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt       <= 1'b0;
            last      <= 1'b1;
            lat_we    <= 1'b0;
            cnt       <= 4'd0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt       <= gnt_next;
                        last      <= gnt_next;
                        lat_we    <= gnt_next ? port1.we    : port0.we;
                        lat_addr  <= gnt_next ? port1.addr  : port0.addr;
                        lat_wdata <= gnt_next ? port1.wdata : port0.wdata;
                        cnt       <= CNT_INIT;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == 4'd0) begin
                        // Writes leave the port's rdata register untouched.
                        if (!lat_we) begin
                            if (gnt) rdata1_q <= mem_rdata;
                            else     rdata0_q <= mem_rdata;
                        end
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory side is driven from latched values only, so requester changes
    // during an access never reach the memory.
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_re    = (state == ST_ACCESS) & ~lat_we;
    assign mem_we    = (state == ST_ACCESS) & lat_we & (cnt == CNT_INIT);
    assign busy      = (state != ST_IDLE);

    assign port0.ack   = (state == ST_RESP) & ~gnt;
    assign port1.ack   = (state == ST_RESP) & gnt;
    assign port0.rdata = rdata0_q;
    assign port1.rdata = rdata1_q;
    assign port0.stall = port0.req & ~port0.ack;
    assign port1.stall = port1.req & ~port1.ack;

endmodule
